gp_ctx_seq: RTL and testbench

GP_CTX_SEQ -- requirements
Module: gp_ctx_seq

---
 rtl/gp_ctx_seq_if.sv | 36 +++
 rtl/gp_ctx_seq.sv | 104 ++++++++++
 tb/tb_gp_ctx_seq.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gp_ctx_seq_if.sv
// rtl/gp_ctx_seq_if.sv - control, register-file and stream signals of the GP context sequencer
interface gp_ctx_seq_if #(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 16
) ();
  logic              iw_save_start;
  logic              iw_restore_start;
  logic              iw_abort;
  logic              ow_busy;
  logic              ow_done;
  logic [IDX_W-1:0]  ow_rf_read_addr;
  logic [DATA_W-1:0] iw_rf_read_data;
  logic [IDX_W-1:0]  ow_rf_write_addr;
  logic [DATA_W-1:0] ow_rf_write_data;
  logic              ow_rf_write_enable;
  logic [DATA_W-1:0] ow_out_data;
  logic              ow_out_valid;
  logic              iw_out_ready;
  logic [DATA_W-1:0] iw_in_data;
  logic              iw_in_valid;
  logic              ow_in_ready;

  modport master (
    input  iw_save_start, iw_restore_start, iw_abort, iw_rf_read_data,
           iw_out_ready, iw_in_data, iw_in_valid,
    output ow_busy, ow_done, ow_rf_read_addr, ow_rf_write_addr, ow_rf_write_data,
           ow_rf_write_enable, ow_out_data, ow_out_valid, ow_in_ready
  );

  modport slave (
    output iw_save_start, iw_restore_start, iw_abort, iw_rf_read_data,
           iw_out_ready, iw_in_data, iw_in_valid,
    input  ow_busy, ow_done, ow_rf_read_addr, ow_rf_write_addr, ow_rf_write_data,
           ow_rf_write_enable, ow_out_data, ow_out_valid, ow_in_ready
  );
endinterface

// File: rtl/gp_ctx_seq.sv
// rtl/gp_ctx_seq.sv - streams all GP registers out (save) or in (restore) over valid/ready
module gp_ctx_seq #(
  parameter int IDX_W = 4,
  parameter int N_REG = 16
) (
  input  logic          iw_clk,
  input  logic          iw_rst_n,
  gp_ctx_seq_if.master  bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_SAVE, ST_RESTORE, ST_DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REG - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge iw_clk) begin
    if (!iw_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d                = state_q;
    cnt_d                  = cnt_q;
    bus.ow_busy            = 1'b0;
    bus.ow_done            = 1'b0;
    bus.ow_rf_read_addr    = '0;
    bus.ow_rf_write_addr   = '0;
    bus.ow_rf_write_data   = '0;
    bus.ow_rf_write_enable = 1'b0;
    bus.ow_out_data        = '0;
    bus.ow_out_valid       = 1'b0;
    bus.ow_in_ready        = 1'b0;

    // Outputs stay quiet while reset is held, even before the first reset edge.
    if (iw_rst_n) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.iw_save_start) begin
            state_d = ST_SAVE;
            cnt_d   = '0;
          end else if (bus.iw_restore_start) begin
            state_d = ST_RESTORE;
            cnt_d   = '0;
          end
        end

        ST_SAVE: begin
          bus.ow_busy         = 1'b1;
          bus.ow_out_valid    = 1'b1;
          bus.ow_rf_read_addr = cnt_q;
          bus.ow_out_data     = bus.iw_rf_read_data;
          // Abort takes priority over the last-word move to DONE; the word itself still goes.
          if (bus.iw_abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (bus.iw_out_ready) begin
            if (cnt_q == LAST_IDX) begin
              state_d = ST_DONE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end

        ST_RESTORE: begin
          bus.ow_busy            = 1'b1;
          bus.ow_in_ready        = 1'b1;
          bus.ow_rf_write_enable = bus.iw_in_valid;
          bus.ow_rf_write_addr   = cnt_q;
          bus.ow_rf_write_data   = bus.iw_in_data;
          if (bus.iw_abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (bus.iw_in_valid) begin
            if (cnt_q == LAST_IDX) begin
              state_d = ST_DONE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end

        ST_DONE: begin
          bus.ow_done = 1'b1;
          state_d     = ST_IDLE;
          cnt_d       = '0;
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gp_ctx_seq.sv
// tb/tb_gp_ctx_seq.sv - directed bench with a per-cycle transfer-level model of gp_ctx_seq
module tb_gp_ctx_seq;
  localparam int IDX_W  = 4;
  localparam int DATA_W = 16;
  localparam int N      = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gp_ctx_seq_if #(.IDX_W(IDX_W), .DATA_W(DATA_W)) sif ();

  gp_ctx_seq #(.IDX_W(IDX_W), .N_REG(N)) dut (
    .iw_clk   (clk),
    .iw_rst_n (rst_n),
    .bus      (sif)
  );

  // Register file shared with the sequencer; combinational read.
  logic [DATA_W-1:0] rf [N];
  logic              pre_go   = 1'b0;
  logic [DATA_W-1:0] pre_base = '0;
  assign sif.iw_rf_read_data = rf[sif.ow_rf_read_addr];

  always @(posedge clk) begin
    if (pre_go) begin
      for (int k = 0; k < N; k++) rf[k] <= pre_base + DATA_W'(k);
    end else if (sif.ow_rf_write_enable) begin
      rf[sif.ow_rf_write_addr] <= sif.ow_rf_write_data;
    end
  end

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Model: an operation is "save" (1) or "restore" (2) with m_k words moved so far.
  int                m_op = 0;
  int                m_k  = 0;
  bit                m_dn = 1'b0;
  logic [DATA_W-1:0] snap [N];
  int                cyc  = 0;
  logic [DATA_W-1:0] out_log [$];
  int                xfer_cyc [$];
  int                n_writes = 0, n_done = 0, busy_cycles = 0, done_cyc = 0;

  always @(negedge clk) begin
    int op_e;
    bit dn_e;
    cyc++;
    op_e = rst_n ? m_op : 0;
    dn_e = rst_n ? m_dn : 1'b0;
    chk("busy",      sif.ow_busy,            op_e != 0);
    chk("done",      sif.ow_done,            dn_e);
    chk("out_valid", sif.ow_out_valid,       op_e == 1);
    chk("out_data",  sif.ow_out_data,        (op_e == 1) ? snap[m_k] : 0);
    chk("rd_addr",   sif.ow_rf_read_addr,    (op_e == 1) ? m_k : 0);
    chk("in_ready",  sif.ow_in_ready,        op_e == 2);
    chk("wr_en",     sif.ow_rf_write_enable, (op_e == 2) && sif.iw_in_valid);
    chk("wr_addr",   sif.ow_rf_write_addr,   (op_e == 2) ? m_k : 0);
    chk("wr_data",   sif.ow_rf_write_data,   (op_e == 2) ? sif.iw_in_data : 0);

    if (sif.ow_out_valid && sif.iw_out_ready) begin
      out_log.push_back(sif.ow_out_data);
      xfer_cyc.push_back(cyc);
    end
    if (sif.ow_rf_write_enable) n_writes++;
    if (sif.ow_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (sif.ow_busy) busy_cycles++;

    if (!rst_n) begin
      m_op = 0; m_k = 0; m_dn = 1'b0;
    end else if (m_dn) begin
      m_dn = 1'b0;
    end else if (m_op == 0) begin
      if (sif.iw_save_start) begin
        m_op = 1; m_k = 0;
        for (int k = 0; k < N; k++) snap[k] = rf[k];
      end else if (sif.iw_restore_start) begin
        m_op = 2; m_k = 0;
      end
    end else begin
      if ((m_op == 1 && sif.iw_out_ready) || (m_op == 2 && sif.iw_in_valid)) m_k++;
      if (sif.iw_abort) begin
        m_op = 0; m_k = 0;
      end else if (m_k == N) begin
        m_op = 0; m_k = 0; m_dn = 1'b1;
      end
    end
  end

  int b_log, b_wr, b_done, b_busy;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mark();
    b_log  = out_log.size();
    b_wr   = n_writes;
    b_done = n_done;
    b_busy = busy_cycles;
  endtask

  task automatic preload(input logic [DATA_W-1:0] base);
    pre_base = base;
    pre_go   = 1'b1;
    step();
    pre_go   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (sif.ow_done) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk({tag, "_done_seen"}, seen, 1);
  endtask

  task automatic wait_words(input string tag, input int n);
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (out_log.size() - b_log == n) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk({tag, "_words_seen"}, seen, 1);
  endtask

  task automatic start_save();
    sif.iw_save_start = 1'b1;
    step();
    sif.iw_save_start = 1'b0;
  endtask

  initial begin
    int start_cyc;
    int acc;
    bit hs;
    sif.iw_save_start    = 1'b0;
    sif.iw_restore_start = 1'b0;
    sif.iw_abort         = 1'b0;
    sif.iw_out_ready     = 1'b0;
    sif.iw_in_data       = '0;
    sif.iw_in_valid      = 1'b0;

    // Reset with a start pulse present: nothing may leave idle.
    sif.iw_save_start = 1'b1;
    repeat (3) step();
    chk("rst_busy",      sif.ow_busy, 0);
    chk("rst_out_valid", sif.ow_out_valid, 0);
    chk("rst_in_ready",  sif.ow_in_ready, 0);
    sif.iw_save_start = 1'b0;
    rst_n = 1'b1;
    step();
    sif.iw_abort = 1'b1;
    step();
    sif.iw_abort = 1'b0;
    chk("idle_abort_busy", sif.ow_busy, 0);

    // Full save with the sink always ready.
    preload(16'h0100);
    mark();
    sif.iw_out_ready = 1'b1;
    start_cyc = cyc + 1;
    start_save();
    wait_done("t1");
    step();
    chk("t1_nwords", out_log.size() - b_log, N);
    for (int k = 0; k < N; k++) chk($sformatf("t1_word%0d", k), out_log[b_log + k], 16'h0100 + k);
    chk("t1_first_word_cyc", xfer_cyc[b_log], start_cyc + 1);
    chk("t1_busy_cycles", busy_cycles - b_busy, N);
    chk("t1_ndone", n_done - b_done, 1);
    chk("t1_done_after_last", done_cyc, xfer_cyc[b_log + N - 1] + 1);

    // Restore with the source valid every other cycle.
    mark();
    sif.iw_restore_start = 1'b1;
    step();
    sif.iw_restore_start = 1'b0;
    acc = 0;
    for (int i = 0; i < 200 && acc < N; i++) begin
      sif.iw_in_valid = (i % 2 == 0);
      sif.iw_in_data  = DATA_W'(16'h00A0 + acc);
      hs = sif.iw_in_valid && sif.ow_in_ready;
      step();
      if (hs) acc++;
    end
    sif.iw_in_valid = 1'b0;
    chk("t2_accepted", acc, N);
    wait_done("t2");
    step();
    chk("t2_nwrites", n_writes - b_wr, N);
    chk("t2_ndone", n_done - b_done, 1);
    for (int k = 0; k < N; k++) chk($sformatf("t2_rf%0d", k), rf[k], 16'h00A0 + k);
    mark();
    start_save();
    wait_done("t2rb");
    step();
    for (int k = 0; k < N; k++) chk($sformatf("t2_readback%0d", k), out_log[b_log + k], 16'h00A0 + k);

    // Sink stalls for five cycles while register 3 is presented.
    preload(16'h0100);
    mark();
    start_save();
    wait_words("t3", 3);
    sif.iw_out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      chk("t3_stall_data", sif.ow_out_data, 16'h0103);
      step();
    end
    sif.iw_out_ready = 1'b1;
    wait_done("t3");
    step();
    chk("t3_nwords", out_log.size() - b_log, N);
    chk("t3_word3", out_log[b_log + 3], 16'h0103);
    chk("t3_word4", out_log[b_log + 4], 16'h0104);

    // Both starts together pick save; restore re-pulsed mid-save is ignored.
    mark();
    sif.iw_out_ready     = 1'b0;
    sif.iw_save_start    = 1'b1;
    sif.iw_restore_start = 1'b1;
    step();
    sif.iw_save_start    = 1'b0;
    chk("t4_out_valid", sif.ow_out_valid, 1);
    chk("t4_in_ready", sif.ow_in_ready, 0);
    step();
    sif.iw_restore_start = 1'b0;
    sif.iw_out_ready     = 1'b1;
    wait_done("t4");
    sif.iw_save_start = 1'b1;
    step();
    sif.iw_save_start = 1'b0;
    chk("t4_start_in_done_busy", sif.ow_busy, 0);
    chk("t4_nwrites", n_writes - b_wr, 0);
    chk("t4_nwords", out_log.size() - b_log, N);

    // Abort while word 5 is being accepted.
    preload(16'h0100);
    mark();
    sif.iw_restore_start = 1'b1;
    step();
    sif.iw_restore_start = 1'b0;
    sif.iw_in_valid = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      sif.iw_in_data = DATA_W'(16'h00B0 + k);
      sif.iw_abort   = (k == 5);
      step();
    end
    sif.iw_abort    = 1'b0;
    sif.iw_in_valid = 1'b0;
    chk("t5_busy_after_abort", sif.ow_busy, 0);
    repeat (3) step();
    chk("t5_ndone", n_done - b_done, 0);
    chk("t5_nwrites", n_writes - b_wr, 6);
    for (int k = 0; k < N; k++)
      chk($sformatf("t5_rf%0d", k), rf[k], (k <= 5) ? 16'h00B0 + k : 16'h0100 + k);

    // Abort on the final save word: word goes out, no done.
    preload(16'h0100);
    mark();
    start_save();
    wait_words("t6", N - 1);
    sif.iw_abort = 1'b1;
    step();
    sif.iw_abort = 1'b0;
    repeat (3) step();
    chk("t6_nwords", out_log.size() - b_log, N);
    chk("t6_ndone", n_done - b_done, 0);

    // Reset mid-save at index 7, with start and abort also asserted.
    mark();
    start_save();
    wait_words("t7", 7);
    rst_n = 1'b0;
    sif.iw_save_start = 1'b1;
    sif.iw_abort      = 1'b1;
    step();
    chk("t7_rst_busy",    sif.ow_busy, 0);
    chk("t7_rst_valid",   sif.ow_out_valid, 0);
    chk("t7_rst_data",    sif.ow_out_data, 0);
    chk("t7_rst_rdaddr",  sif.ow_rf_read_addr, 0);
    rst_n = 1'b1;
    sif.iw_save_start = 1'b0;
    sif.iw_abort      = 1'b0;
    step();
    chk("t7_post_rst_busy", sif.ow_busy, 0);
    chk("t7_ndone", n_done - b_done, 0);
    mark();
    start_save();
    wait_done("t7");
    step();
    chk("t7_nwords", out_log.size() - b_log, N);
    chk("t7_first_word", out_log[b_log], 16'h0100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
